// File: rtl/mv_pkg.sv
// mv_pkg: shared types and constants for the matrix-vector result path.
package mv_pkg;
  localparam int MV_OUT_WORDS = 5;
  localparam int MV_ID_MAX = 32;
  typedef enum logic [2:0] {
    W_ID = 3'd0,
    W_X  = 3'd1,
    W_Y  = 3'd2,
    W_Z  = 3'd3,
    W_W  = 3'd4
  } mv_word_e;
  typedef struct packed {
    logic [MV_ID_MAX-1:0] id;
    logic [31:0] ox;
    logic [31:0] oy;
    logic [31:0] oz;
    logic [31:0] ow;
  } mv_result_t;
endpackage

// File: rtl/mv_sync_fifo.sv
// mv_sync_fifo: synchronous FIFO with occupancy count; entry 0 is reset-cleared so dout reads 0 after reset.
module mv_sync_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign do_push = push && count != (AW+1)'(DEPTH);
  assign do_pop = pop && count != '0;
  assign dout = mem[rp];
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
    if (rst) mem[0] <= '0;
  end
endmodule

// File: rtl/mv_out_serializer.sv
// mv_out_serializer: buffers transformed vertices and re-emits them as id/ox/oy/oz/ow word frames.
import mv_pkg::*;
module mv_out_serializer #(
  parameter int IDW = 8,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           s_valid,
  output logic           s_ready,
  input  logic [IDW-1:0] s_vertex_id,
  input  logic [31:0]    s_ox,
  input  logic [31:0]    s_oy,
  input  logic [31:0]    s_oz,
  input  logic [31:0]    s_ow,
  output logic           m_valid,
  input  logic           m_ready,
  output logic [31:0]    m_data,
  output logic           m_last,
  output logic [15:0]    frames_sent
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam mv_word_e LAST = mv_word_e'(3'(MV_OUT_WORDS - 1));
  mv_word_e st, st_nxt;
  mv_result_t din, head;
  logic [CW-1:0] count;
  logic push, pop, fire;
  assign s_ready = !rst && count < CW'(DEPTH);
  assign push = s_valid && s_ready;
  assign m_valid = count != '0;
  assign fire = m_valid && m_ready;
  assign pop = fire && st == LAST;
  assign m_last = m_valid && st == LAST;
  assign din = '{id: MV_ID_MAX'(s_vertex_id), ox: s_ox, oy: s_oy, oz: s_oz, ow: s_ow};
  assign m_data = st == W_ID ? head.id :
                  st == W_X  ? head.ox :
                  st == W_Y  ? head.oy :
                  st == W_Z  ? head.oz : head.ow;
  mv_sync_fifo #(.W($bits(mv_result_t)), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .din(din),
    .pop(pop),
    .dout(head),
    .count(count)
  );
  always_ff @(posedge clk) begin
    st <= rst ? W_ID : st_nxt;
    frames_sent <= rst ? 16'd0 : frames_sent + 16'(pop);
  end
  always_comb begin
    st_nxt = st;
    if (fire) st_nxt = st == LAST ? W_ID : mv_word_e'(st + 3'd1);
  end
endmodule

// File: tb/tb_mv_out_serializer.sv
// tb_mv_out_serializer: table vectors, hand sequences and a queue-based word-stream model.
module tb_mv_out_serializer;
  localparam int DEPTH = 4;
  typedef struct {
    logic [7:0]  id;
    logic [31:0] x, y, z, w;
  } vtx_t;
  typedef struct {
    logic        sv, mr;
    logic        mv;
    logic        md_chk;
    logic [31:0] md;
    logic        ml, sr;
    logic [15:0] fs;
  } vec_t;
  logic clk = 0, rst = 1;
  logic s_valid = 0, s_ready, m_valid, m_ready = 0, m_last;
  logic [7:0] s_vertex_id = 0;
  logic [31:0] s_ox = 0, s_oy = 0, s_oz = 0, s_ow = 0, m_data;
  logic [15:0] frames_sent;
  int vectors = 0, miscompares = 0, acc = 0;
  logic [31:0] wq[$];
  vtx_t pq[$];
  logic [15:0] exp_fs = 0;
  logic rst_d = 0, hs = 0, auto_on = 0, rand_mr = 0, stalled = 0, pl = 0;
  logic [31:0] pd = 0;
  vec_t tv[7];
  logic [31:0] spec[4];

  mv_out_serializer #(.IDW(8), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
    .s_vertex_id(s_vertex_id), .s_ox(s_ox), .s_oy(s_oy), .s_oz(s_oz), .s_ow(s_ow),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  // Reference: expected output is the concatenation of 5-word frames of every accepted vertex.
  always @(posedge clk) begin
    if (rst) begin
      chk("rst_s_ready", 32'(s_ready), 0);
      if (rst_d) begin
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_m_last", 32'(m_last), 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_frames", 32'(frames_sent), 0);
      end
      wq.delete();
      exp_fs = 0;
      stalled = 0;
      hs = 0;
    end else begin
      chk("s_ready", 32'(s_ready), 32'((wq.size() + 4) / 5 < DEPTH));
      chk("m_valid", 32'(m_valid), 32'(wq.size() != 0));
      chk("frames_sent", 32'(frames_sent), 32'(exp_fs));
      if (wq.size() != 0) begin
        chk("m_data", m_data, wq[0]);
        chk("m_last", 32'(m_last), 32'(wq.size() % 5 == 1));
      end
      if (stalled) begin
        chk("hold_data", m_data, pd);
        chk("hold_last", 32'(m_last), 32'(pl));
      end
      stalled = m_valid && !m_ready;
      pd = m_data;
      pl = m_last;
      if (m_valid && m_ready && wq.size() != 0) begin
        if (wq.size() % 5 == 1) exp_fs++;
        void'(wq.pop_front());
      end
      hs = s_valid && s_ready;
      if (hs) begin
        wq.push_back({24'd0, s_vertex_id});
        wq.push_back(s_ox);
        wq.push_back(s_oy);
        wq.push_back(s_oz);
        wq.push_back(s_ow);
        acc++;
      end
    end
    rst_d = rst;
  end

  // Upstream: holds each vertex until it is accepted.
  initial forever begin
    @(negedge clk);
    if (auto_on) begin
      if (hs && pq.size() != 0) void'(pq.pop_front());
      s_valid = pq.size() != 0;
      if (s_valid) begin
        s_vertex_id = pq[0].id;
        s_ox = pq[0].x;
        s_oy = pq[0].y;
        s_oz = pq[0].z;
        s_ow = pq[0].w;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rand_mr) m_ready = 1'($urandom_range(0, 1));
  end

  task automatic wait_drain(input string n, input int budget);
    int k = 0;
    logic done = 0;
    while (!done && k < budget) begin
      @(posedge clk);
      #1;
      k++;
      done = pq.size() == 0 && !s_valid && wq.size() == 0;
    end
    chk(n, 32'(done), 1);
  endtask

  function automatic logic [31:0] rnd_word();
    return $urandom_range(0, 5) == 0 ? spec[$urandom_range(0, 3)] : $urandom;
  endfunction

  initial begin
    int a0;
    vtx_t v;
    spec[0] = 32'h7FC00000; spec[1] = 32'h7F800000; spec[2] = 32'hFF800000; spec[3] = 32'h80000000;
    tv[0] = '{1, 1, 1, 1, 32'h0000002A, 0, 1, 0};
    tv[1] = '{0, 1, 1, 1, 32'h3F800000, 0, 1, 0};
    tv[2] = '{0, 1, 1, 1, 32'h40000000, 0, 1, 0};
    tv[3] = '{0, 0, 1, 1, 32'h40000000, 0, 1, 0};
    tv[4] = '{0, 1, 1, 1, 32'hBF800000, 0, 1, 0};
    tv[5] = '{0, 1, 1, 1, 32'h7FC00000, 1, 1, 0};
    tv[6] = '{0, 1, 0, 0, 32'h0, 0, 1, 1};
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("reset_s_ready", 32'(s_ready), 0);
      chk("reset_m_valid", 32'(m_valid), 0);
      chk("reset_frames", 32'(frames_sent), 0);
    end
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
    chk("release_s_ready", 32'(s_ready), 1);

    s_vertex_id = 8'h2A; s_ox = 32'h3F800000; s_oy = 32'h40000000; s_oz = 32'hBF800000; s_ow = 32'h7FC00000;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      s_valid = tv[i].sv;
      m_ready = tv[i].mr;
      @(posedge clk);
      #1;
      chk($sformatf("tv%0d_m_valid", i), 32'(m_valid), 32'(tv[i].mv));
      if (tv[i].md_chk) chk($sformatf("tv%0d_m_data", i), m_data, tv[i].md);
      chk($sformatf("tv%0d_m_last", i), 32'(m_last), 32'(tv[i].ml));
      chk($sformatf("tv%0d_s_ready", i), 32'(s_ready), 32'(tv[i].sr));
      chk($sformatf("tv%0d_frames", i), 32'(frames_sent), 32'(tv[i].fs));
    end

    @(negedge clk);
    m_ready = 0;
    a0 = acc;
    for (int i = 0; i < 6; i++) pq.push_back('{8'(i), 32'h10000000 | i, 32'h20000000 | i, 32'h30000000 | i, 32'h40000000 | i});
    auto_on = 1;
    repeat (8) @(posedge clk);
    #1;
    chk("fill_accepted", 32'(acc - a0), DEPTH);
    chk("fill_s_ready", 32'(s_ready), 0);
    chk("fill_head_id", m_data, 0);
    @(negedge clk);
    m_ready = 1;
    repeat (4) @(posedge clk);
    #1;
    chk("full_ow_last", 32'(m_last), 1);
    chk("full_ow_s_ready", 32'(s_ready), 0);
    @(posedge clk);
    #1;
    chk("full_pop_no_push", 32'(acc - a0), DEPTH);
    chk("full_pop_s_ready", 32'(s_ready), 1);
    chk("full_pop_next_id", m_data, 1);
    @(posedge clk);
    #1;
    chk("full_push_next", 32'(acc - a0), DEPTH + 1);
    wait_drain("fill_drain", 300);
    chk("fill_frames", 32'(frames_sent), 7);

    for (int i = 0; i < 50; i++) begin
      v.id = 8'($urandom);
      v.x = rnd_word(); v.y = rnd_word(); v.z = rnd_word(); v.w = rnd_word();
      pq.push_back(v);
    end
    rand_mr = 1;
    wait_drain("stall_drain", 3000);
    rand_mr = 0;
    @(negedge clk);
    m_ready = 1;
    @(posedge clk);
    #1;
    chk("stall_frames", 32'(frames_sent), 57);

    pq.push_back('{8'h11, 32'hA1, 32'hA2, 32'hA3, 32'hA4});
    repeat (4) @(posedge clk);
    #1;
    chk("mid_at_oz", m_data, 32'hA3);
    @(negedge clk);
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
    chk("mid_rst_frames", 32'(frames_sent), 0);
    chk("mid_rst_m_valid", 32'(m_valid), 0);
    pq.push_back('{8'h55, 32'hB1, 32'hB2, 32'hB3, 32'hB4});
    @(posedge clk);
    #1;
    chk("mid_restart_id", m_data, 32'h55);
    chk("mid_restart_last", 32'(m_last), 0);
    wait_drain("mid_drain", 50);
    chk("mid_frames", 32'(frames_sent), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mv_out_serializer.md
# mv_out_serializer

Receiver for the 4x4 FP32 matrix-vector multiplier's result port. It accepts one transformed vertex per handshake (id plus ox/oy/oz/ow) and drives the multiplier's `out_ready`. Results are buffered in a small FIFO and re-emitted as a 32-bit word stream in the same 5-word-per-vertex layout as the golden output hex files: id word, then ox, oy, oz, ow. The stream feeds the result writer and bench scoreboards.

## Interface
- `IDW`, default 8: vertex id width, must be ≤ 32.
- `DEPTH`, default 4: FIFO entries, power of 2, ≥ 2.
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `s_valid` in 1: result valid; connects to the multiplier's `out_valid`.
- `s_ready` out 1: space available; connects to the multiplier's `out_ready`.
- `s_vertex_id` in IDW: result vertex id.
- `s_ox`, `s_oy`, `s_oz`, `s_ow` in 32 each: FP32 result components, raw bits.
- `m_valid` out 1: output word valid.
- `m_ready` in 1: downstream accepts the word.
- `m_data` out 32: output word.
- `m_last` out 1: high on the ow word, the 5th word of a frame.
- `frames_sent` out 16: count of completed frames; wraps 0xFFFF→0.

## Operation
- Push:
  - Occurs when `s_valid && s_ready`.
  - Writes {id, ox, oy, oz, ow} at the write pointer.
  - `s_ready = !rst && (count < DEPTH)`. It depends only on registered count. There is no same-cycle pass-through when full.
- Serializer: a word-index FSM with states W_ID(0), W_X(1), W_Y(2), W_Z(3), W_W(4), operating on the FIFO head.
  - `m_valid = (count != 0)`.
  - `m_data`:
    - W_ID: `{zero-extend(id) to 32}`.
    - W_X, W_Y, W_Z, W_W: ox, oy, oz, ow respectively.
  - `m_last = m_valid && state==W_W`.
  - On `m_valid && m_ready`:
    - State advances 0→1→2→3→4.
    - From W_W: state returns to W_ID, the head entry is popped, and `frames_sent` increments.
  - With no handshake: state, `m_data` and `m_last` hold. AXI-stream rule: once asserted, `m_valid` stays high and the data stays stable until accepted.
- Count update: +1 on push only, −1 on pop only, unchanged on simultaneous push+pop.
- Pointers: log2(DEPTH) bits, wrap naturally.
- Data handling: pure bit transport. No FP interpretation; NaN, Inf and −0 pass unchanged.
- Reset:
  - Clears count, pointers, FSM (→W_ID) and `frames_sent`.
  - Storage contents are don't-care.
  - A frame in flight when reset asserts is discarded. After reset, the stream restarts at an id word.

## Timing
- Reset values:
  - `s_ready`=0 while rst is high, and 1 the cycle after rst falls.
  - `m_valid`=0, `m_last`=0, `frames_sent`=0.
  - `m_data`=0. The head entry is muxed, but storage is reset-cleared for entry 0 only to guarantee this.
- Latency: first push at edge N gives `m_valid`=1 and `m_data`=id after edge N. The word is observable in cycle N+1.
- Throughput:
  - 1 word/cycle with `m_ready` held high, so 5 cycles per vertex.
  - The upstream sustained rate is therefore 1 vertex per 5 cycles. Bursts up to DEPTH are absorbed.
- Full:
  - `s_ready` drops in the cycle after the DEPTH-th push.
  - It rises in the cycle after the pop that frees an entry, i.e. after the ow handshake.
- Empty: after the last pop, `m_valid` is 0 in the next cycle.
- The multiplier must hold `out_valid` and data while `s_ready`=0. This block never drops a result.

## Structure
- Shared package `mv_pkg`:
  - `mv_result_t` packed struct: id[IDW], ox, oy, oz, ow.
  - Word-index enum `mv_word_e` (W_ID..W_W).
  - Constant `MV_OUT_WORDS = 5`.
- Natural sub-module: `mv_sync_fifo` (generic width/depth, count output), reused by future vertex-input buffering.
- The top holds the FSM, output mux and frame counter.

## Test plan
- Reset: hold rst 5 cycles → `s_ready`=0, `m_valid`=0, `frames_sent`=0; cycle after release → `s_ready`=1.
- Single vertex:
  - Stimulus: id=0x2A, ox=0x3F800000, oy=0x40000000, oz=0xBF800000, ow=0x7FC00000, `m_ready`=1.
  - Expect words 0x0000002A, 3F800000, 40000000, BF800000, 7FC00000.
  - `m_last` only on the 5th word; `frames_sent`=1.
- Backpressure fill:
  - Stimulus: `m_ready`=0, offer 6 vertices on consecutive cycles.
  - Expect exactly DEPTH=4 accepted, then `s_ready`=0, with the 5th held upstream.
  - Release `m_ready`: 30 words in id order 0..5, no loss or duplication.
- Random `m_ready` stall: toggle `m_ready` pseudo-randomly over 50 vertices.
  - Expect `m_data`/`m_last` stable while stalled.
  - Output stream equals the golden 5-word-per-case hex sequence bit-exactly.
- Simultaneous push/pop at full: with count=4 and the ow word handshaking in the same cycle as an `s_valid` offer, expect no push that cycle (`s_ready`=0), count→3, and the push accepted next cycle.
- Reset mid-frame: assert rst after the oy word → next frame after reset begins with the id word, and `frames_sent` restarts at 0.
